// File: rtl/if_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES_DEF = 32'd4;

    typedef logic [1:0] state_t;

    localparam state_t S_REQ  = 2'd0;
    localparam state_t S_HOLD = 2'd1;
    localparam state_t S_DROP = 2'd2;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response handshake between fetch stage and memory.
interface if_fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_pc_reg.sv
// Fetch PC and outstanding-request address registers.
module if_pc_reg
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_target,
    input  logic        load_addr_target,
    input  logic        advance,
    input  logic        resync,
    input  logic [31:0] target,
    input  logic [31:0] inc_base,
    output logic [31:0] pc,
    output logic [31:0] addr_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
        end else if (advance) begin
            pc     <= inc_base + INSTR_BYTES;
            addr_q <= inc_base + INSTR_BYTES;
        end else begin
            if (load_target)
                pc <= target;
            // resync re-points the request at the redirect PC once the stale word drains
            if (load_addr_target)
                addr_q <= target;
            else if (resync)
                addr_q <= pc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and steers IF/ID.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    if_fetch_stage_if.master imem,
    output logic [31:0] instruction,
    output logic [31:0] next_pc,
    output logic        if_id_load_enable,
    output logic        if_id_reset,
    output logic [31:0] pc
);

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] hold_instr, hold_pc;
    logic        req, done, capture;
    logic        load_target, load_addr_target, advance, resync;
    logic [31:0] inc_base;

    assign req  = !reset && (state != S_HOLD);
    assign done = req && imem.imem_ready;

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr_q;

    if_pc_reg #(
        .RESET_PC    (RESET_PC),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_pc_reg (
        .clk              (clk),
        .reset            (reset),
        .load_target      (load_target),
        .load_addr_target (load_addr_target),
        .advance          (advance),
        .resync           (resync),
        .target           (branch_target),
        .inc_base         (inc_base),
        .pc               (pc),
        .addr_q           (addr_q)
    );

    always_comb begin
        state_nxt         = state;
        if_id_load_enable = 1'b1;
        if_id_reset       = 1'b1;
        instruction       = 32'h0;
        next_pc           = 32'h0;
        load_target       = 1'b0;
        load_addr_target  = 1'b0;
        advance           = 1'b0;
        resync            = 1'b0;
        capture           = 1'b0;
        inc_base          = addr_q;
        if (reset) begin
            state_nxt = S_REQ;
        end else if (branch_taken) begin
            load_target = 1'b1;
            case (state)
                S_REQ: begin
                    if (done)
                        load_addr_target = 1'b1;
                    else
                        state_nxt = S_DROP;
                end
                S_HOLD: begin
                    load_addr_target = 1'b1;
                    state_nxt        = S_REQ;
                end
                default: ;
            endcase
        end else if (stall_in) begin
            if_id_load_enable = 1'b0;
            case (state)
                S_REQ: begin
                    if (done) begin
                        capture   = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
                S_HOLD: ;
                default: begin
                    if (done) begin
                        resync    = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (done) begin
                        advance     = 1'b1;
                        if_id_reset = 1'b0;
                        instruction = imem.imem_rdata;
                        next_pc     = addr_q + INSTR_BYTES;
                    end
                end
                S_HOLD: begin
                    advance     = 1'b1;
                    inc_base    = hold_pc;
                    if_id_reset = 1'b0;
                    instruction = hold_instr;
                    next_pc     = hold_pc + INSTR_BYTES;
                    state_nxt   = S_REQ;
                end
                default: begin
                    if (done) begin
                        resync    = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_instr <= imem.imem_rdata;
                hold_pc    <= addr_q;
            end
        end
    end

endmodule
